dance_round_sequencer: RTL and testbench
========================================

// Module: dance_round_sequencer
// PURPOSE
//  Game-flow controller for the pose-judging datapath. Drives its 2-bit pattern_state (0=live camera,
//  2=guide/preview, 3=freeze+judge) over NUM_ROUNDS rounds, captures each 3-bit judgement on the
//  datapath's done pulse, and keeps per-round and total score. Sits between the game/UART control
//  logic and the detect/display datapath.
// PARAMETERS
//  NUM_ROUNDS     8    rounds per game (1..15)
//  PREVIEW_FRAMES 90   frames in GUIDE (state 2) per round (>=1)
//  JUDGE_TIMEOUT  4    frames to wait in JUDGE for judge_done before forcing BAD (>=2)
//  SHOW_FRAMES    60   frames holding JUDGE view after a result (>=1)
// PORTS
//  clk            in   1  system clock
//  reset          in   1  synchronous, active-high reset
//  start          in   1  1-cycle pulse: begin a game (ignored unless IDLE or DONE)
//  abort          in   1  level: return to IDLE next cycle, counters cleared
//  frame_tick     in   1  1-cycle pulse once per video frame (end of frame)
//  judge_done     in   1  1-cycle pulse from datapath; result valid this cycle
//  result         in   3  100=PERFECT, 010=GOOD, 001=BAD; other codes treated as BAD
//  pattern_state  out  2  mode to datapath
//  round_idx      out  4  current round, 0-based
//  round_result   out  3  latched judgement of last finished round
//  result_valid   out  1  1-cycle pulse when round_result updates
//  score          out  8  total: PERFECT=+2, GOOD=+1, BAD=+0
//  busy           out  1  high in GUIDE/JUDGE/SHOW
//  game_done      out  1  level, high in DONE
// BEHAVIOUR
//  Reset (sync): state=IDLE, pattern_state=0, round_idx=0, round_result=0, result_valid=0,
//   score=0, busy=0, game_done=0, frame counter=0. All outputs registered.
//  States / pattern_state: IDLE(0) GUIDE(2) JUDGE(3) SHOW(3) DONE(0).
//  IDLE/DONE --start--> GUIDE; clears score, round_idx, frame counter; game_done drops.
//  GUIDE: count frame_tick; on PREVIEW_FRAMES-th tick -> JUDGE, counter cleared.
//  JUDGE: count frame_tick. On judge_done: latch result (non-one-hot -> 001), result_valid=1
//   next cycle, score += weight, -> SHOW. If JUDGE_TIMEOUT ticks elapse without judge_done:
//   latch 001, pulse result_valid, -> SHOW. judge_done and final timeout tick in same cycle:
//   judge_done wins. judge_done outside JUDGE: ignored.
//  SHOW: count SHOW_FRAMES ticks; then if round_idx==NUM_ROUNDS-1 -> DONE, else round_idx++, -> GUIDE.
//  DONE: game_done=1, score/round_result hold until next start or reset.
//  abort (any state): -> IDLE next cycle, round_idx=0, score=0, counter=0; round_result holds;
//   abort has priority over start and judge_done in the same cycle. reset beats abort.
//  start while busy: ignored. frame_tick is only counted, never edge-detected; one tick = one count.
//  Latency: state change and pattern_state update 1 cycle after the triggering pulse.
//  Score saturates at 255 (unreachable with defaults; max 2*NUM_ROUNDS).
//  Frame counter width = clog2(max(PREVIEW_FRAMES,SHOW_FRAMES,JUDGE_TIMEOUT)+1); no wrap.
// TESTING
//  T1 reset then idle 100 ticks -> pattern_state=0, busy=0, score=0, no result_valid.
//  T2 NUM_ROUNDS=2,PREVIEW=3,SHOW=2: start, judge_done w/ 100 then 010 -> pattern 2,3,3,2,3,3,0;
//     score=3, game_done=1, round_idx=1.
//  T3 no judge_done, JUDGE_TIMEOUT=4 -> after 4th tick in JUDGE round_result=001, result_valid pulse.
//  T4 judge_done with result=011 -> treated BAD: round_result=001, score unchanged.
//  T5 abort asserted mid-JUDGE together with judge_done -> IDLE next cycle, score=0, no result_valid.
//  T6 start pulse during GUIDE -> ignored (frame count and round_idx unchanged); start in DONE restarts.

Source files
------------

// File: rtl/dance_round_sequencer.sv
// Game-flow controller: walks GUIDE -> JUDGE -> SHOW for each round, latches the
// per-round judgement and keeps a saturating total score for the display datapath.
module dance_round_sequencer #(
  parameter int NUM_ROUNDS     = 8,
  parameter int PREVIEW_FRAMES = 90,
  parameter int JUDGE_TIMEOUT  = 4,
  parameter int SHOW_FRAMES    = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       frame_tick,
  input  logic       judge_done,
  input  logic [2:0] result,
  output logic [1:0] pattern_state,
  output logic [3:0] round_idx,
  output logic [2:0] round_result,
  output logic       result_valid,
  output logic [7:0] score,
  output logic       busy,
  output logic       game_done,
  output logic [2:0] dbg_state_o
);

  localparam int MAX_PS = (PREVIEW_FRAMES > SHOW_FRAMES) ? PREVIEW_FRAMES : SHOW_FRAMES;
  localparam int MAX_F  = (MAX_PS > JUDGE_TIMEOUT) ? MAX_PS : JUDGE_TIMEOUT;
  localparam int CW     = $clog2(MAX_F + 1);

  localparam logic [CW-1:0] PREV_LAST  = CW'(PREVIEW_FRAMES - 1);
  localparam logic [CW-1:0] JUDGE_LAST = CW'(JUDGE_TIMEOUT - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_FRAMES - 1);
  localparam logic [3:0]    ROUND_LAST = 4'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GUIDE = 3'd1,
    S_JUDGE = 3'd2,
    S_SHOW  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    round_q, round_d;
  logic [2:0]    rr_q, rr_d;
  logic          rv_q, rv_d;
  logic [7:0]    score_q, score_d;
  logic [1:0]    pattern_q, pattern_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [2:0]    judged;
  logic [1:0]    weight;
  logic [8:0]    sum;

  // Anything that is not a clean one-hot PERFECT/GOOD code scores as BAD.
  always_comb begin
    judged = 3'b001;
    weight = 2'd0;
    if (result == 3'b100) begin
      judged = 3'b100;
      weight = 2'd2;
    end else if (result == 3'b010) begin
      judged = 3'b010;
      weight = 2'd1;
    end
    sum = {1'b0, score_q} + 9'(weight);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    rr_d    = rr_q;
    rv_d    = 1'b0;
    score_d = score_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      round_d = '0;
      score_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_GUIDE;
            cnt_d   = '0;
            round_d = '0;
            score_d = '0;
          end
        end
        S_GUIDE: begin
          if (frame_tick) begin
            if (cnt_q == PREV_LAST) begin
              state_d = S_JUDGE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_JUDGE: begin
          // judge_done takes precedence over a coincident final timeout tick.
          if (judge_done) begin
            state_d = S_SHOW;
            cnt_d   = '0;
            rr_d    = judged;
            rv_d    = 1'b1;
            score_d = sum[8] ? 8'hFF : sum[7:0];
          end else if (frame_tick) begin
            if (cnt_q == JUDGE_LAST) begin
              state_d = S_SHOW;
              cnt_d   = '0;
              rr_d    = 3'b001;
              rv_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_SHOW: begin
          if (frame_tick) begin
            if (cnt_q == SHOW_LAST) begin
              cnt_d = '0;
              if (round_q == ROUND_LAST) begin
                state_d = S_DONE;
              end else begin
                round_d = round_q + 1'b1;
                state_d = S_GUIDE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Mode outputs are decoded from the next state so they change with the state register.
  always_comb begin
    pattern_d = 2'd0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      S_GUIDE: begin
        pattern_d = 2'd2;
        busy_d    = 1'b1;
      end
      S_JUDGE, S_SHOW: begin
        pattern_d = 2'd3;
        busy_d    = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: pattern_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      round_q   <= '0;
      rr_q      <= '0;
      rv_q      <= 1'b0;
      score_q   <= '0;
      pattern_q <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      round_q   <= round_d;
      rr_q      <= rr_d;
      rv_q      <= rv_d;
      score_q   <= score_d;
      pattern_q <= pattern_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign pattern_state = pattern_q;
  assign round_idx     = round_q;
  assign round_result  = rr_q;
  assign result_valid  = rv_q;
  assign score         = score_q;
  assign busy          = busy_q;
  assign game_done     = done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dance_round_sequencer.sv
// Directed bench for dance_round_sequencer with a short game (2 rounds, 3 preview, 4 timeout, 2 show).
module tb_dance_round_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       frame_tick;
  logic       judge_done;
  logic [2:0] result;
  logic [1:0] pattern_state;
  logic [3:0] round_idx;
  logic [2:0] round_result;
  logic       result_valid;
  logic [7:0] score;
  logic       busy;
  logic       game_done;
  logic [2:0] dbg_state_o;

  int n_checks;
  int n_fail;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GUIDE = 3'd1;
  localparam logic [2:0] ST_JUDGE = 3'd2;
  localparam logic [2:0] ST_SHOW  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  dance_round_sequencer #(
    .NUM_ROUNDS    (2),
    .PREVIEW_FRAMES(3),
    .JUDGE_TIMEOUT (4),
    .SHOW_FRAMES   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .frame_tick   (frame_tick),
    .judge_done   (judge_done),
    .result       (result),
    .pattern_state(pattern_state),
    .round_idx    (round_idx),
    .round_result (round_result),
    .result_valid (result_valid),
    .score        (score),
    .busy         (busy),
    .game_done    (game_done),
    .dbg_state_o  (dbg_state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: each starts and ends on a falling edge, so outputs are sampled there.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_judge(input logic [2:0] r);
    judge_done = 1'b1;
    result     = r;
    @(negedge clk);
    judge_done = 1'b0;
    result     = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    n_checks++;
    if (pattern_state !== 2'd0 || busy !== 1'b0 || game_done !== 1'b0 || dbg_state_o !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_mode: pattern=%0d busy=%b done=%b st=%0d, want 0 0 0 0",
               pattern_state, busy, game_done, dbg_state_o);
    end
    n_checks++;
    if (score !== 8'd0 || round_idx !== 4'd0 || round_result !== 3'd0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: score=%0d round=%0d rr=%b rv=%b, want 0 0 000 0",
               score, round_idx, round_result, result_valid);
    end
  endtask

  task automatic test_idle();
    logic seen_rv;
    seen_rv = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (result_valid) seen_rv = 1'b1;
    end
    n_checks++;
    if (seen_rv !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_rv: result_valid seen=%b, want 0", seen_rv);
    end
    n_checks++;
    if (pattern_state !== 2'd0 || busy !== 1'b0 || score !== 8'd0) begin
      n_fail++;
      $display("FAIL idle_hold: pattern=%0d busy=%b score=%0d, want 0 0 0", pattern_state, busy, score);
    end
  endtask

  task automatic test_full_game();
    pulse_start();
    n_checks++;
    if (pattern_state !== 2'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL game_guide0: pattern=%0d busy=%b, want 2 1", pattern_state, busy);
    end
    ticks(2);
    n_checks++;
    if (pattern_state !== 2'd2) begin
      n_fail++;
      $display("FAIL game_preview2: pattern=%0d, want 2", pattern_state);
    end
    tick();
    n_checks++;
    if (pattern_state !== 2'd3 || dbg_state_o !== ST_JUDGE) begin
      n_fail++;
      $display("FAIL game_judge0: pattern=%0d st=%0d, want 3 %0d", pattern_state, dbg_state_o, ST_JUDGE);
    end
    pulse_judge(3'b100);
    n_checks++;
    if (result_valid !== 1'b1 || round_result !== 3'b100 || score !== 8'd2 || dbg_state_o !== ST_SHOW) begin
      n_fail++;
      $display("FAIL game_perfect: rv=%b rr=%b score=%0d st=%0d, want 1 100 2 %0d",
               result_valid, round_result, score, dbg_state_o, ST_SHOW);
    end
    cyc();
    n_checks++;
    if (result_valid !== 1'b0 || pattern_state !== 2'd3) begin
      n_fail++;
      $display("FAIL game_rv_pulse: rv=%b pattern=%0d, want 0 3", result_valid, pattern_state);
    end
    ticks(2);
    n_checks++;
    if (pattern_state !== 2'd2 || round_idx !== 4'd1) begin
      n_fail++;
      $display("FAIL game_guide1: pattern=%0d round=%0d, want 2 1", pattern_state, round_idx);
    end
    ticks(3);
    pulse_judge(3'b010);
    n_checks++;
    if (round_result !== 3'b010 || score !== 8'd3 || result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL game_good: rr=%b score=%0d rv=%b, want 010 3 1", round_result, score, result_valid);
    end
    ticks(2);
    n_checks++;
    if (pattern_state !== 2'd0 || game_done !== 1'b1 || busy !== 1'b0 || round_idx !== 4'd1 || score !== 8'd3) begin
      n_fail++;
      $display("FAIL game_done: pattern=%0d done=%b busy=%b round=%0d score=%0d, want 0 1 0 1 3",
               pattern_state, game_done, busy, round_idx, score);
    end
    ticks(5);
    n_checks++;
    if (game_done !== 1'b1 || score !== 8'd3 || round_result !== 3'b010) begin
      n_fail++;
      $display("FAIL done_hold: done=%b score=%0d rr=%b, want 1 3 010", game_done, score, round_result);
    end
  endtask

  task automatic test_restart_from_done();
    pulse_start();
    n_checks++;
    if (pattern_state !== 2'd2 || score !== 8'd0 || round_idx !== 4'd0 || game_done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: pattern=%0d score=%0d round=%0d done=%b busy=%b, want 2 0 0 0 1",
               pattern_state, score, round_idx, game_done, busy);
    end
  endtask

  task automatic test_start_in_guide();
    tick();
    pulse_start();
    pulse_judge(3'b100);
    n_checks++;
    if (pattern_state !== 2'd2 || score !== 8'd0 || result_valid !== 1'b0 || round_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL guide_ignore: pattern=%0d score=%0d rv=%b round=%0d, want 2 0 0 0",
               pattern_state, score, result_valid, round_idx);
    end
    ticks(2);
    n_checks++;
    if (pattern_state !== 2'd3 || dbg_state_o !== ST_JUDGE) begin
      n_fail++;
      $display("FAIL guide_count_kept: pattern=%0d st=%0d, want 3 %0d", pattern_state, dbg_state_o, ST_JUDGE);
    end
  endtask

  task automatic test_timeout();
    ticks(3);
    n_checks++;
    if (dbg_state_o !== ST_JUDGE || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: st=%0d rv=%b, want %0d 0", dbg_state_o, result_valid, ST_JUDGE);
    end
    tick();
    n_checks++;
    if (result_valid !== 1'b1 || round_result !== 3'b001 || score !== 8'd0 || dbg_state_o !== ST_SHOW) begin
      n_fail++;
      $display("FAIL timeout_bad: rv=%b rr=%b score=%0d st=%0d, want 1 001 0 %0d",
               result_valid, round_result, score, dbg_state_o, ST_SHOW);
    end
  endtask

  task automatic test_done_vs_timeout();
    ticks(2);
    ticks(3);
    ticks(3);
    frame_tick = 1'b1;
    judge_done = 1'b1;
    result     = 3'b100;
    cyc();
    frame_tick = 1'b0;
    judge_done = 1'b0;
    result     = 3'b000;
    n_checks++;
    if (round_result !== 3'b100 || score !== 8'd2 || result_valid !== 1'b1 || round_idx !== 4'd1) begin
      n_fail++;
      $display("FAIL done_wins: rr=%b score=%0d rv=%b round=%0d, want 100 2 1 1",
               round_result, score, result_valid, round_idx);
    end
    ticks(2);
    n_checks++;
    if (game_done !== 1'b1 || score !== 8'd2) begin
      n_fail++;
      $display("FAIL done_wins_end: done=%b score=%0d, want 1 2", game_done, score);
    end
  endtask

  task automatic test_bad_code();
    pulse_start();
    ticks(3);
    pulse_judge(3'b010);
    ticks(2);
    ticks(3);
    pulse_judge(3'b011);
    n_checks++;
    if (round_result !== 3'b001 || score !== 8'd1 || result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_code: rr=%b score=%0d rv=%b, want 001 1 1", round_result, score, result_valid);
    end
    ticks(2);
    n_checks++;
    if (game_done !== 1'b1 || score !== 8'd1) begin
      n_fail++;
      $display("FAIL bad_code_end: done=%b score=%0d, want 1 1", game_done, score);
    end
  endtask

  task automatic test_abort();
    pulse_start();
    ticks(3);
    pulse_judge(3'b100);
    ticks(2);
    ticks(3);
    abort      = 1'b1;
    judge_done = 1'b1;
    result     = 3'b010;
    cyc();
    abort      = 1'b0;
    judge_done = 1'b0;
    result     = 3'b000;
    n_checks++;
    if (dbg_state_o !== ST_IDLE || pattern_state !== 2'd0 || busy !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_mode: st=%0d pattern=%0d busy=%b rv=%b, want 0 0 0 0",
               dbg_state_o, pattern_state, busy, result_valid);
    end
    n_checks++;
    if (score !== 8'd0 || round_idx !== 4'd0 || round_result !== 3'b100) begin
      n_fail++;
      $display("FAIL abort_regs: score=%0d round=%0d rr=%b, want 0 0 100", score, round_idx, round_result);
    end
    cyc();
    n_checks++;
    if (result_valid !== 1'b0 || dbg_state_o !== ST_IDLE) begin
      n_fail++;
      $display("FAIL abort_after: rv=%b st=%0d, want 0 0", result_valid, dbg_state_o);
    end
  endtask

  task automatic test_reset_beats_abort();
    pulse_start();
    reset = 1'b1;
    abort = 1'b1;
    cyc();
    reset = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (round_result !== 3'b000 || dbg_state_o !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_over_abort: rr=%b st=%0d, want 000 0", round_result, dbg_state_o);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    frame_tick = 1'b0;
    judge_done = 1'b0;
    result     = 3'b000;
    test_reset();
    test_idle();
    test_full_game();
    test_restart_from_done();
    test_start_in_guide();
    test_timeout();
    test_done_vs_timeout();
    test_bad_code();
    test_abort();
    test_reset_beats_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
